key_matrix_scan_ctrl: RTL and testbench

Scan controller for a 4x4 active-low matrix keypad. Drives the columns one at a time, samples the rows, and debounces whole-keypad snapshots over consecutive scans. Emits one debounced key-code event per press on a valid/ready interface toward the UI/control logic. It replaces per-key edge debouncers with a single time-shared scanner for the board keypad.

---
 rtl/key_matrix_scan_ctrl_pkg.sv | 21 ++
 rtl/key_matrix_scan_ctrl_if.sv | 9 +
 rtl/key_matrix_scan_ctrl_col_scanner.sv | 46 ++++
 rtl/key_matrix_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_key_matrix_scan_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/key_matrix_scan_ctrl_pkg.sv
// key_pkg: keypad geometry, FSM state type and snapshot decode helpers for key_matrix_scan_ctrl.
package key_pkg;
    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 4;
    localparam int KEY_CODE_W = 4;
    localparam int KEY_N      = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} key_state_e;

    function automatic logic one_hot(input logic [KEY_N-1:0] s);
        return s != '0 && (s & (s - 1'b1)) == '0;
    endfunction

    function automatic logic [KEY_CODE_W-1:0] key_index(input logic [KEY_N-1:0] s);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_N; i++)
            if (s[i]) idx = KEY_CODE_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/key_matrix_scan_ctrl_if.sv
// key_matrix_scan_ctrl_if: valid/ready key-event channel from the scanner to the UI logic.
interface key_matrix_scan_ctrl_if;
    import key_pkg::*;
    logic                  key_valid;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_ready;
    modport master (output key_valid, key_code, input key_ready);
    modport slave  (input key_valid, key_code, output key_ready);
endinterface

// File: rtl/key_matrix_scan_ctrl_col_scanner.sv
// key_col_scanner: column rotation, row synchroniser and full-keypad snapshot with a per-scan strobe.
module key_col_scanner
    import key_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_ROWS-1:0] row_n,
    output logic [KEY_COLS-1:0] col_n,
    output logic [KEY_N-1:0]    snapshot,
    output logic                scan_done
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(KEY_COLS);

    logic [DIV_W-1:0]    div_cnt;
    logic [COL_W-1:0]    col;
    logic [KEY_ROWS-1:0] row_s1, row_s2;
    logic                cap;

    assign cap = div_cnt == DIV_W'(SCAN_DIV - 1);

    // Capture at the end of the dwell so the synchroniser has settled on this column's rows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1    <= '1;
            row_s2    <= '1;
            div_cnt   <= '0;
            col       <= '0;
            col_n     <= 4'b1110;
            snapshot  <= '0;
            scan_done <= 1'b0;
        end else begin
            row_s1    <= row_n;
            row_s2    <= row_s1;
            div_cnt   <= cap ? '0 : div_cnt + 1'b1;
            scan_done <= cap && col == COL_W'(KEY_COLS - 1);
            if (cap) begin
                snapshot[col*KEY_ROWS +: KEY_ROWS] <= ~row_s2;
                col   <= col + 1'b1;
                col_n <= ~(KEY_COLS'(1) << (col + 1'b1));
            end
        end
    end
endmodule

// File: rtl/key_matrix_scan_ctrl.sv
// key_matrix_scan_ctrl: 4x4 keypad scanner with snapshot debounce and one-entry event output.
// Define KEY_REPEAT_EN to add auto-repeat events while a key stays held.
module key_matrix_scan_ctrl
    import key_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 250,
    parameter int REPEAT_RATE    = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_ROWS-1:0]   row_n,
    output logic [KEY_COLS-1:0]   col_n,
    key_matrix_scan_ctrl_if.master kif,
    output logic                  key_pressed,
    output logic                  event_drop
);
    localparam int DCNT_W = $clog2(DEBOUNCE_SCANS + 1);

    if (SCAN_DIV < 2) begin : g_bad_div
        $error("SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_deb
        $error("DEBOUNCE_SCANS must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
        $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [KEY_N-1:0]      snapshot;
    logic                  scan_done;
    logic                  single, hit, emit, rpt_fire, load;
    logic [KEY_CODE_W-1:0] code, cand, emit_code;
    logic [DCNT_W-1:0]     dcnt;
    key_state_e            state;

    key_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .snapshot (snapshot),
        .scan_done(scan_done)
    );

    // Multi-key snapshots decode as "no key" so ghosting never produces a code
    assign single    = one_hot(snapshot);
    assign code      = key_index(snapshot);
    assign hit       = single && code == cand;
    assign emit_code = state == IDLE ? code : cand;
    assign emit      = scan_done && ((state == IDLE && single && DEBOUNCE_SCANS == 1) ||
                                     (state == DEBOUNCE && hit && dcnt == DCNT_W'(DEBOUNCE_SCANS - 1)))
                       || rpt_fire;
    assign load      = emit && (!kif.key_valid || kif.key_ready);

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed;

    assign rpt_fire = scan_done && state == PRESSED && hit &&
                      int'(rpt_cnt) + 1 == (rpt_armed ? REPEAT_RATE : REPEAT_DELAY);

    // Any scan that leaves PRESSED clears the counter, so RELEASE sees it held at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (scan_done && state == PRESSED) begin
            rpt_cnt   <= (!hit || rpt_fire) ? '0 : rpt_cnt + 1'b1;
            rpt_armed <= hit && (rpt_armed || rpt_fire);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cand          <= '0;
            dcnt          <= '0;
            key_pressed   <= 1'b0;
            kif.key_valid <= 1'b0;
            kif.key_code  <= '0;
            event_drop    <= 1'b0;
        end else begin
            kif.key_valid <= emit || (kif.key_valid && !kif.key_ready);
            kif.key_code  <= load ? emit_code : kif.key_code;
            event_drop    <= emit && !load;
            if (scan_done) begin
                case (state)
                    IDLE: if (single) begin
                        cand        <= code;
                        dcnt        <= DCNT_W'(1);
                        state       <= DEBOUNCE_SCANS == 1 ? PRESSED : DEBOUNCE;
                        key_pressed <= DEBOUNCE_SCANS == 1;
                    end
                    DEBOUNCE: if (!hit) state <= IDLE;
                    else begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == DCNT_W'(DEBOUNCE_SCANS - 1)) begin
                            state       <= PRESSED;
                            key_pressed <= 1'b1;
                        end
                    end
                    PRESSED: if (!hit) begin
                        dcnt        <= DCNT_W'(1);
                        state       <= DEBOUNCE_SCANS == 1 ? IDLE : RELEASE;
                        key_pressed <= DEBOUNCE_SCANS != 1;
                    end
                    RELEASE: if (hit) state <= PRESSED;
                    else begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == DCNT_W'(DEBOUNCE_SCANS - 1)) begin
                            state       <= IDLE;
                            key_pressed <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_key_matrix_scan_ctrl.sv
// tb_key_matrix_scan_ctrl: keypad-model bench with an expected-event scoreboard for key_matrix_scan_ctrl.
module tb_key_matrix_scan_ctrl;
    localparam int SD  = 4;
    localparam int DS  = 3;
    localparam int SCN = 4 * SD;
    localparam int LAT = DS * SCN + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n, col_n;
    logic        key_pressed, event_drop;
    logic [15:0] held = '0;

    int         checks = 0, failures = 0, hs_cnt = 0, drop_cnt = 0;
    logic [3:0] exp_q[$];

    key_matrix_scan_ctrl_if kif();

    key_matrix_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .kif        (kif),
        .key_pressed(key_pressed),
        .event_drop (event_drop)
    );

    always #5 clk = ~clk;

    // Keypad: a held key shorts its row low while its column is driven
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (held[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (event_drop) drop_cnt++;
        if (kif.key_valid && kif.key_ready) begin
            hs_cnt++;
            chk("evt_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("evt_code", kif.key_code, exp_q.pop_front());
        end
    end

    task automatic wait_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Returns on the first negedge of a new scan (column 0 just driven after column 3)
    task automatic align();
        logic [3:0] prev;
        int n;
        prev = col_n;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (col_n == 4'b1110 && prev == 4'b0111) break;
            prev = col_n;
        end
        chk("align_timeout", n < 64, 1);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (kif.key_valid) break;
        end
        chk(tag, n, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        int d0, h0;
        kif.key_ready = 1'b1;
        wait_n(3);
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_valid", kif.key_valid, 0);
        chk("rst_code", kif.key_code, 0);
        chk("rst_pressed", key_pressed, 0);
        chk("rst_drop", event_drop, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            e = ~(4'b0001 << (k / 4));
            chk("col_seq", col_n, e);
            if (k % 4 == 0) chk("idle_valid", kif.key_valid, 0);
            @(negedge clk);
        end
        chk("idle_pressed", key_pressed, 0);
        chk("idle_drops", drop_cnt, 0);

        // Clean press of key 6, released after 10 scans
        align();
        held[6] = 1'b1;
        exp_q.push_back(4'd6);
        wait_valid("t2_latency", LAT);
        wait_n(1);
        chk("t2_valid_pulse", kif.key_valid, 0);
        chk("t2_pressed", key_pressed, 1);
        wait_n(10 * SCN - LAT - 1);
        chk("t2_phase", col_n, 4'b1110);
        held = '0;
        wait_n(DS * SCN);
        chk("t2_pressed_hold", key_pressed, 1);
        wait_n(1);
        chk("t2_pressed_fall", key_pressed, 0);

        // Bounce: 2 scans on, 1 off, 6 on
        align();
        held[6] = 1'b1;
        exp_q.push_back(4'd6);
        wait_n(2 * SCN);
        held = '0;
        wait_n(SCN);
        held[6] = 1'b1;
        wait_valid("t3_latency", LAT);
        wait_n(6 * SCN - LAT);
        held = '0;
        wait_n(5 * SCN);
        chk("t3_pressed", key_pressed, 0);

        // Back-pressure: key 3 held in the register, key 9 dropped
        @(posedge clk);
        #1 kif.key_ready = 1'b0;
        align();
        held[3] = 1'b1;
        exp_q.push_back(4'd3);
        wait_valid("t4_latency", LAT);
        d0 = drop_cnt;
        wait_n(SCN - 1);
        held = '0;
        wait_n(DS * SCN);
        held[9] = 1'b1;
        wait_n(DS * SCN + 12);
        held = '0;
        chk("t4_drop_once", drop_cnt - d0, 1);
        chk("t4_valid_held", kif.key_valid, 1);
        chk("t4_code_held", kif.key_code, 3);
        @(posedge clk);
        #1 kif.key_ready = 1'b1;
        wait_n(2);
        chk("t4_valid_clear", kif.key_valid, 0);
        wait_n(5 * SCN);

        // Two keys together: ghosting rejected
        align();
        h0 = hs_cnt;
        held[0] = 1'b1;
        held[5] = 1'b1;
        for (int s = 0; s < 8; s++) begin
            wait_n(SCN);
            chk("t5_pressed", key_pressed, 0);
        end
        held = '0;
        chk("t5_no_event", hs_cnt - h0, 0);
        chk("t5_valid", kif.key_valid, 0);

        // Reset during debounce of key 12
        align();
        held[12] = 1'b1;
        wait_n(SCN + 4);
        rst_n = 1'b0;
        wait_n(3);
        chk("t6_rst_valid", kif.key_valid, 0);
        chk("t6_rst_col", col_n, 4'b1110);
        rst_n = 1'b1;
        exp_q.push_back(4'd12);
        wait_valid("t6_latency", LAT);
        wait_n(SCN);
        held = '0;
        wait_n(5 * SCN);
        chk("t6_pressed", key_pressed, 0);

        chk("evt_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
